// File: rtl/micro_program_automate_core.sv
// rtl/micro_program_automate_core.sv - CAMAC S1/S2 strobe sequencer and local register strobe
// Host drops sel to start a cycle; rdy stays low until the sequence reaches DONE.
module micro_program_automate_core #(
  parameter int C1_LEN  = 4,
  parameter int GAP_LEN = 2,
  parameter int C2_LEN  = 4,
  parameter int REG_LEN = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] a,
  input  logic       w,
  input  logic       sel,
  input  logic       tim,
  input  logic       ie,
  input  logic       cx1,
  output logic       rdy,
  output logic       c1,
  output logic       c2,
  output logic       sel2,
  output logic       x0,
  output logic       x1
);

  localparam int MAX_A   = (C1_LEN > GAP_LEN) ? C1_LEN : GAP_LEN;
  localparam int MAX_B   = (C2_LEN > REG_LEN) ? C2_LEN : REG_LEN;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] C1_LAST  = CW'(C1_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] C2_LAST  = CW'(C2_LEN - 1);
  localparam logic [CW-1:0] REG_LAST = CW'(REG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_C1,
    S_GAP,
    S_C2,
    S_REG,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_reg_acc;
  logic          r_write;

  // Outputs are set on the transition into a state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_reg_acc <= 1'b0;
      r_write   <= 1'b0;
      rdy       <= 1'b1;
      c1        <= 1'b0;
      c2        <= 1'b0;
      sel2      <= 1'b0;
      x0        <= 1'b0;
      x1        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!sel) begin
            r_reg_acc <= a[1];
            r_write   <= w;
            r_state   <= S_LATCH;
            rdy       <= 1'b0;
            x1        <= 1'b0;
          end
        end

        S_LATCH: begin
          r_cnt <= '0;
          if (!r_reg_acc) begin
            r_state <= S_C1;
            c1      <= 1'b1;
            x0      <= 1'b0;
          end else begin
            r_state <= S_REG;
            sel2    <= 1'b1;
          end
        end

        S_C1: begin
          if (!tim) begin
            if (r_cnt == C1_LAST) begin
              r_cnt <= '0;
              c1    <= 1'b0;
              x0    <= cx1;
              if (r_write) begin
                r_state <= S_GAP;
              end else begin
                r_state <= S_DONE;
                rdy     <= 1'b1;
                x1      <= ie & cx1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_C2;
            c2      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_C2: begin
          if (!tim) begin
            if (r_cnt == C2_LAST) begin
              r_cnt   <= '0;
              c2      <= 1'b0;
              r_state <= S_DONE;
              rdy     <= 1'b1;
              x1      <= ie & x0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_REG: begin
          if (r_cnt == REG_LAST) begin
            r_cnt   <= '0;
            sel2    <= 1'b0;
            r_state <= S_DONE;
            rdy     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          if (sel) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          rdy     <= 1'b1;
          c1      <= 1'b0;
          c2      <= 1'b0;
          sel2    <= 1'b0;
        end
      endcase

      // Interrupt enable low masks the request on every clock.
      if (!ie) begin
        x1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_micro_program_automate_core.sv
// tb/tb_micro_program_automate_core.sv - scoreboard bench for micro_program_automate_core
module tb_micro_program_automate_core;

  localparam int C1_LEN  = 4;
  localparam int GAP_LEN = 2;
  localparam int C2_LEN  = 4;
  localparam int REG_LEN = 2;

  logic       clk;
  logic       reset_n;
  logic [1:0] a;
  logic       w;
  logic       sel;
  logic       tim;
  logic       ie;
  logic       cx1;
  logic       rdy;
  logic       c1;
  logic       c2;
  logic       sel2;
  logic       x0;
  logic       x1;

  int n_cmp;
  int n_err;
  bit model_x0;

  typedef struct {
    int rdy_low;
    int c1_n;
    int c1_first;
    int c2_n;
    int c2_first;
    int sel2_n;
    int sel2_first;
    int x0;
    int x1;
  } exp_t;

  exp_t sb_q[$];

  micro_program_automate_core #(
    .C1_LEN (C1_LEN),
    .GAP_LEN(GAP_LEN),
    .C2_LEN (C2_LEN),
    .REG_LEN(REG_LEN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .a      (a),
    .w      (w),
    .sel    (sel),
    .tim    (tim),
    .ie     (ie),
    .cx1    (cx1),
    .rdy    (rdy),
    .c1     (c1),
    .c2     (c2),
    .sel2   (sel2),
    .x0     (x0),
    .x1     (x1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // tim_len clocks of hold are assumed to land inside C1 (tim_at within clocks 2..5).
  task automatic run_txn(input string name, input logic [1:0] ta, input logic tw,
                         input logic tcx1, input logic tie, input int tim_at,
                         input int tim_len, input int sel_rise_at);
    exp_t e;
    exp_t got;
    int   k;
    bit   done;
    e = '{default: 0};
    if (ta[1]) begin
      e.rdy_low    = 1 + REG_LEN;
      e.sel2_n     = REG_LEN;
      e.sel2_first = 2;
      e.x0         = int'(model_x0);
      e.x1         = 0;
    end else begin
      e.c1_first = 2;
      e.c1_n     = C1_LEN + tim_len;
      if (tw) begin
        e.c2_first = 2 + C1_LEN + tim_len + GAP_LEN;
        e.c2_n     = C2_LEN;
        e.rdy_low  = 1 + C1_LEN + tim_len + GAP_LEN + C2_LEN;
      end else begin
        e.rdy_low = 1 + C1_LEN + tim_len;
      end
      e.x0     = int'(tcx1);
      e.x1     = int'(tie & tcx1);
      model_x0 = tcx1;
    end
    sb_q.push_back(e);

    @(negedge clk);
    a   = ta;
    w   = tw;
    cx1 = tcx1;
    ie  = tie;
    sel = 1'b0;
    got = '{default: 0};
    k    = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (!rdy) got.rdy_low++;
      else done = 1'b1;
      if (c1) begin got.c1_n++; if (got.c1_first == 0) got.c1_first = k; end
      if (c2) begin got.c2_n++; if (got.c2_first == 0) got.c2_first = k; end
      if (sel2) begin got.sel2_n++; if (got.sel2_first == 0) got.sel2_first = k; end
      if (k == 1) begin a = ~ta; w = ~tw; end
      if (k == tim_at) tim = 1'b1;
      if (k == tim_at + tim_len) tim = 1'b0;
      if (k == sel_rise_at) sel = 1'b1;
    end
    if (!done) check({name, "_timeout"}, 0, 1);
    tim = 1'b0;
    if (!sel) begin
      @(negedge clk);
      check({name, "_done_hold"}, int'({rdy, c1, c2, sel2}), 4'b1000);
      sel = 1'b1;
    end
    @(negedge clk);
    got.x0 = int'(x0);
    got.x1 = int'(x1);

    e = sb_q.pop_front();
    check({name, "_rdy_low"}, got.rdy_low, e.rdy_low);
    check({name, "_c1_n"}, got.c1_n, e.c1_n);
    check({name, "_c1_first"}, got.c1_first, e.c1_first);
    check({name, "_c2_n"}, got.c2_n, e.c2_n);
    check({name, "_c2_first"}, got.c2_first, e.c2_first);
    check({name, "_sel2_n"}, got.sel2_n, e.sel2_n);
    check({name, "_sel2_first"}, got.sel2_first, e.sel2_first);
    check({name, "_x0"}, got.x0, e.x0);
    check({name, "_x1"}, got.x1, e.x1);
  endtask

  initial begin
    int k;
    n_cmp    = 0;
    n_err    = 0;
    model_x0 = 1'b0;
    reset_n  = 1'b0;
    a        = 2'd0;
    w        = 1'b0;
    sel      = 1'b1;
    tim      = 1'b0;
    ie       = 1'b0;
    cx1      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", int'({rdy, c1, c2, sel2, x0, x1}), 6'b100000);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_outs", int'({rdy, c1, c2, sel2, x0, x1}), 6'b100000);
    end

    run_txn("read_x", 2'd0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    ie = 1'b0;
    @(negedge clk);
    check("ie_drop_x1", int'(x1), 0);
    run_txn("reg_a2", 2'd2, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    run_txn("write_a1", 2'd1, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    run_txn("write_tim", 2'd0, 1'b1, 1'b1, 1'b1, 3, 10, 0);
    run_txn("read_selrise", 2'd1, 1'b0, 1'b1, 1'b0, 0, 0, 2);
    run_txn("reg_a3", 2'd3, 1'b0, 1'b1, 1'b1, 0, 0, 0);

    // Reset in the middle of the C2 strobe.
    @(negedge clk);
    a   = 2'd0;
    w   = 1'b1;
    cx1 = 1'b1;
    ie  = 1'b1;
    sel = 1'b0;
    for (k = 1; k <= 9; k++) @(negedge clk);
    check("pre_rst_c2", int'({c2, x0}), 2'b11);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_in_c2", int'({rdy, c1, c2, sel2, x0, x1}), 6'b100000);
    reset_n  = 1'b1;
    sel      = 1'b1;
    model_x0 = 1'b0;
    @(negedge clk);
    check("after_rst", int'({rdy, c1, c2, sel2, x0, x1}), 6'b100000);
    run_txn("read_post_rst", 2'd0, 1'b0, 1'b0, 1'b1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
